// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline controller
//   REG_IDX_W   : width of a register index
//   int_state_e : interrupt sequencing FSM states
package pipe_ctrl_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_INJECT = 2'd2,
    ST_ACTIVE = 2'd3
  } int_state_e;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard compare between ID and EX
//   ex_mem_read, ex_rd          : load in EX and its destination
//   id_rs1/id_rs2, id_uses_rs*  : sources of the instruction in ID
//   load_use                    : ID needs a value the EX load has not produced yet
import pipe_ctrl_pkg::*;

module hazard_detect (
  input  logic                 ex_mem_read,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  output logic                 load_use
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
    rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
    // x0 is hardwired to zero, so a load targeting it never creates a dependency
    load_use = ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush/interrupt control for a 5-stage pipeline
//   inputs : id_rs1/id_rs2/id_uses_rs*, ex_mem_read/ex_rd, branch_taken,
//            mem_busy, int_req/int_en, reti_ex
//   outputs: pc_stall, if_id_stall/flush, id_ex_stall/flush, ex_mem_stall,
//            int_inject, int_ack, int_active, mem_timeout (sticky)
import pipe_ctrl_pkg::*;

module pipeline_ctrl #(
  parameter int INT_DRAIN   = 3,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic                 ex_mem_read,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 branch_taken,
  input  logic                 mem_busy,
  input  logic                 int_req,
  input  logic                 int_en,
  input  logic                 reti_ex,
  output logic                 pc_stall,
  output logic                 if_id_stall,
  output logic                 if_id_flush,
  output logic                 id_ex_stall,
  output logic                 id_ex_flush,
  output logic                 ex_mem_stall,
  output logic                 int_inject,
  output logic                 int_ack,
  output logic                 int_active,
  output logic                 mem_timeout
);

  localparam logic [3:0] DRAIN_LOAD  = 4'(INT_DRAIN - 1);
  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  int_state_e state_q, state_d;
  logic [3:0] drain_cnt_q, drain_cnt_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_timeout_q, mem_timeout_d;
  logic       load_use;

  hazard_detect u_hazard (
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .load_use    (load_use)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      drain_cnt_q   <= '0;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      drain_cnt_q   <= drain_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // Interrupt sequencing; a frozen pipeline (mem_busy) freezes the sequence too.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    if (!mem_busy) begin
      case (state_q)
        ST_IDLE: begin
          if (int_req && int_en) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = DRAIN_LOAD;
          end
        end
        ST_DRAIN: begin
          // Branches during drain do not restart the count
          if (drain_cnt_q == 4'd0) state_d = ST_INJECT;
          else                     drain_cnt_d = drain_cnt_q - 4'd1;
        end
        ST_INJECT: state_d = ST_ACTIVE;
        ST_ACTIVE: if (reti_ex) state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Consecutive busy-cycle counter with a sticky timeout flag
  always_comb begin
    wait_cnt_d = '0;
    if (mem_busy) begin
      wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
    end
    mem_timeout_d = mem_timeout_q || (wait_cnt_d >= TIMEOUT_CNT);
  end

  // Outputs follow priority: mem_busy > branch > drain > load-use.
  // Reset forces every output low without waiting for a clock.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    int_inject   = 1'b0;
    int_ack      = 1'b0;
    int_active   = 1'b0;
    mem_timeout  = 1'b0;
    if (rst_n) begin
      int_active  = (state_q == ST_ACTIVE);
      mem_timeout = mem_timeout_q;
      if (mem_busy) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
      end else begin
        // Inject is gated by !mem_busy so the acknowledge stays a single pulse
        if (state_q == ST_INJECT) begin
          int_inject = 1'b1;
          int_ack    = 1'b1;
        end
        if (branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (state_q == ST_DRAIN) begin
          pc_stall    = 1'b1;
          if_id_flush = 1'b1;
        end else if (load_use && (state_q != ST_INJECT)) begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - randomized self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

  localparam int INT_DRAIN   = 3;
  localparam int MEM_TIMEOUT = 255;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_uses_rs1 = 0, id_uses_rs2 = 0, ex_mem_read = 0;
  logic       branch_taken = 0, mem_busy = 0, int_req = 0, int_en = 0, reti_ex = 0;
  logic       pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall;
  logic       int_inject, int_ack, int_active, mem_timeout;
  logic [9:0] obs;
  logic [9:0] exp_v;

  int checks = 0;
  int errors = 0;

  // Reference model: interrupt progress as "cycles left to drain" plus flags
  bit m_draining, m_inject, m_handler, m_timeout;
  int m_drain_left, m_wait;

  always #5 clk = ~clk;

  pipeline_ctrl #(.INT_DRAIN(INT_DRAIN), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .branch_taken(branch_taken),
    .mem_busy(mem_busy), .int_req(int_req), .int_en(int_en), .reti_ex(reti_ex),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush), .ex_mem_stall(ex_mem_stall),
    .int_inject(int_inject), .int_ack(int_ack), .int_active(int_active),
    .mem_timeout(mem_timeout)
  );

  assign obs = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                ex_mem_stall, int_inject, int_ack, int_active, mem_timeout};

  function automatic logic [9:0] expect_out();
    logic       hz;
    logic [9:0] o;
    hz = ex_mem_read && (ex_rd != 0) &&
         ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    o = '0;
    if (!rst_n) return o;
    o[1] = m_handler;
    o[0] = m_timeout;
    if (mem_busy) begin
      o[9] = 1; o[8] = 1; o[6] = 1; o[4] = 1;
    end else begin
      if (m_inject) begin o[3] = 1; o[2] = 1; end
      if (branch_taken)            begin o[7] = 1; o[5] = 1; end
      else if (m_draining)         begin o[9] = 1; o[7] = 1; end
      else if (hz && !m_inject)    begin o[9] = 1; o[8] = 1; o[5] = 1; end
    end
    return o;
  endfunction

  task automatic model_reset();
    m_draining = 0; m_inject = 0; m_handler = 0; m_timeout = 0;
    m_drain_left = 0; m_wait = 0;
  endtask

  task automatic model_step();
    if (mem_busy) m_wait = (m_wait < 255) ? m_wait + 1 : 255;
    else          m_wait = 0;
    if (m_wait >= MEM_TIMEOUT) m_timeout = 1;
    if (!mem_busy) begin
      if (m_inject) begin
        m_inject = 0; m_handler = 1;
      end else if (m_draining) begin
        m_drain_left--;
        if (m_drain_left == 0) begin m_draining = 0; m_inject = 1; end
      end else if (m_handler) begin
        if (reti_ex) m_handler = 0;
      end else if (int_req && int_en) begin
        m_draining = 1; m_drain_left = INT_DRAIN;
      end
    end
  endtask

  // Advance one clock; returns at the following negedge for input changes
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_mem_read = 0; branch_taken = 0; mem_busy = 0; int_req = 0; int_en = 0; reti_ex = 0;
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 0;
    mem_busy = 1; branch_taken = 1; ex_mem_read = 1; ex_rd = 3; id_rs1 = 3; id_uses_rs1 = 1;
    #1;
    checks++;
    if (obs !== 10'b0) begin errors++; $display("FAIL reset_outputs: got %b want %b", obs, 10'b0); end
    @(negedge clk);
    clear_inputs();
    rst_n = 1;
    #1;
    exp_v = expect_out();
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_release: got %b want %b", obs, exp_v); end
    @(negedge clk);
  endtask

  task automatic test_load_use();
    logic [4:0] rd_t[6]  = '{5, 0, 7, 7, 9, 5};
    logic [4:0] rs1_t[6] = '{5, 0, 1, 1, 9, 5};
    logic [4:0] rs2_t[6] = '{2, 0, 7, 7, 3, 2};
    logic       u1_t[6]  = '{1, 1, 0, 0, 1, 1};
    logic       u2_t[6]  = '{0, 1, 1, 0, 0, 0};
    logic       rd_en[6] = '{1, 1, 1, 1, 0, 1};
    for (int i = 0; i < 6; i++) begin
      ex_mem_read = rd_en[i]; ex_rd = rd_t[i]; id_rs1 = rs1_t[i]; id_rs2 = rs2_t[i];
      id_uses_rs1 = u1_t[i]; id_uses_rs2 = u2_t[i];
      #1;
      exp_v = expect_out();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL load_use[%0d]: got %b want %b", i, obs, exp_v); end
      tick();
      // Load has advanced to MEM; the bubble is in EX, so no second stall
      ex_mem_read = 0;
      #1;
      exp_v = expect_out();
      checks++;
      if (obs !== exp_v || pc_stall !== 1'b0) begin
        errors++; $display("FAIL load_use_bubble[%0d]: got %b want %b", i, obs, exp_v);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_branch_priority();
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1; branch_taken = 1;
    #1;
    checks++;
    if (obs !== 10'b0010100000) begin errors++; $display("FAIL branch_over_load: got %b want %b", obs, 10'b0010100000); end
    tick();
    mem_busy = 1;
    #1;
    exp_v = expect_out();
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL busy_over_branch: got %b want %b", obs, exp_v); end
    tick();
    clear_inputs();
  endtask

  task automatic test_interrupt();
    int ack_at = -1;
    int_req = 1; int_en = 1;
    #1;
    exp_v = expect_out();
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL int_request: got %b want %b", obs, exp_v); end
    tick();
    int_req = 0;
    for (int n = 1; n <= 20; n++) begin
      #1;
      exp_v = expect_out();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL int_seq[%0d]: got %b want %b", n, obs, exp_v); end
      if (int_ack) begin ack_at = n; break; end
      tick();
    end
    checks++;
    if (ack_at !== INT_DRAIN + 1) begin errors++; $display("FAIL int_ack_cycle: got %0d want %0d", ack_at, INT_DRAIN + 1); end
    tick();
    int_req = 1;
    for (int n = 0; n < 4; n++) begin
      #1;
      exp_v = expect_out();
      checks++;
      if (obs !== exp_v || int_active !== 1'b1) begin errors++; $display("FAIL int_active[%0d]: got %b want %b", n, obs, exp_v); end
      tick();
    end
    int_req = 0; reti_ex = 1;
    tick();
    reti_ex = 0;
    #1;
    checks++;
    if (int_active !== 1'b0) begin errors++; $display("FAIL reti_exit: got %b want 0", int_active); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_drain_busy();
    int ack_at = -1;
    int_req = 1; int_en = 1;
    tick();
    int_req = 0;
    for (int n = 1; n <= 20; n++) begin
      mem_busy = (n == 2 || n == 3);
      #1;
      exp_v = expect_out();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL drain_busy_seq[%0d]: got %b want %b", n, obs, exp_v); end
      if (int_ack) begin ack_at = n; break; end
      tick();
    end
    checks++;
    if (ack_at !== INT_DRAIN + 3) begin errors++; $display("FAIL drain_busy_ack: got %0d want %0d", ack_at, INT_DRAIN + 3); end
    tick();
    reti_ex = 1;
    tick();
    clear_inputs();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
      ex_rd = 5'($urandom_range(0, 7));
      id_uses_rs1 = 1'($urandom_range(0, 1)); id_uses_rs2 = 1'($urandom_range(0, 1));
      ex_mem_read = 1'($urandom_range(0, 1));
      branch_taken = ($urandom_range(0, 7) == 0);
      mem_busy = ($urandom_range(0, 9) == 0);
      int_req = ($urandom_range(0, 5) == 0);
      int_en = ($urandom_range(0, 3) != 0);
      reti_ex = ($urandom_range(0, 9) == 0);
      #1;
      exp_v = expect_out();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL random[%0d]: got %b want %b", n, obs, exp_v); end
      tick();
    end
    clear_inputs();
    // Let any sequence in flight settle back to idle
    reti_ex = 1;
    repeat (INT_DRAIN + 4) tick();
    clear_inputs();
  endtask

  task automatic test_timeout();
    mem_busy = 1;
    for (int k = 0; k <= 256; k++) begin
      #1;
      exp_v = expect_out();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL timeout_seq[%0d]: got %b want %b", k, obs, exp_v); end
      if (k == MEM_TIMEOUT - 1 || k == MEM_TIMEOUT) begin
        checks++;
        if (mem_timeout !== (k >= MEM_TIMEOUT)) begin
          errors++; $display("FAIL timeout_edge[%0d]: got %b want %b", k, mem_timeout, k >= MEM_TIMEOUT);
        end
      end
      tick();
    end
    mem_busy = 0;
    tick();
    tick();
    #1;
    checks++;
    if (mem_timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b want 1", mem_timeout); end
    @(negedge clk);
  endtask

  task automatic test_reset_active();
    int_req = 1; int_en = 1;
    tick();
    int_req = 0;
    repeat (INT_DRAIN + 1) tick();
    #1;
    checks++;
    if (int_active !== 1'b1) begin errors++; $display("FAIL pre_reset_active: got %b want 1", int_active); end
    rst_n = 0;
    model_reset();
    mem_busy = 1;
    #1;
    checks++;
    if (obs !== 10'b0) begin errors++; $display("FAIL reset_in_active: got %b want %b", obs, 10'b0); end
    @(negedge clk);
    mem_busy = 0;
    rst_n = 1;
    for (int n = 0; n < 6; n++) begin
      #1;
      exp_v = expect_out();
      checks++;
      if (obs !== exp_v || int_ack !== 1'b0) begin errors++; $display("FAIL post_reset[%0d]: got %b want %b", n, obs, exp_v); end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load_use();
    test_branch_priority();
    test_interrupt();
    test_drain_busy();
    test_random();
    test_timeout();
    test_reset_active();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter INT_DRAIN, default 3: cycles the front end is held before interrupt injection (legal 1..15).
REQ-002 Parameter MEM_TIMEOUT, default 255: consecutive mem_busy cycles before timeout (legal 1..255).
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
REQ-006 id_uses_rs1, id_uses_rs2  in  1 each  source actually read.
REQ-007 ex_mem_read  in  1  instruction in EX is a load; ex_rd  in  5  its destination.
REQ-008 branch_taken  in  1  EX resolved a taken branch/jump this cycle.
REQ-009 mem_busy  in  1  data memory not ready; pipeline must freeze.
REQ-010 int_req  in  1  level interrupt request; int_en  in  1  global enable.
REQ-011 reti_ex  in  1  return-from-interrupt is in EX.
REQ-012 pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall  out  1 each  pipeline register controls.
REQ-013 int_inject  out  1  drives IF/ID interrupt input; int_ack  out  1  one-cycle acknowledge.
REQ-014 int_active  out  1  handler running; mem_timeout  out  1  sticky memory timeout flag.

Function
REQ-015 Control outputs SHALL be combinational from inputs and registered state, effective the same cycle.
REQ-016 Priority, highest first: mem_busy, branch_taken, interrupt DRAIN, load-use.
REQ-017 mem_busy=1: all four stall outputs 1, both flushes 0, FSM and drain counter hold.
REQ-018 branch_taken=1 (mem_busy=0): if_id_flush=1, id_ex_flush=1, stalls 0.
REQ-019 Load-use hazard = ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
REQ-020 Load-use (no higher event): pc_stall=1, if_id_stall=1, id_ex_flush=1, others 0; exactly one bubble per hazard.
REQ-021 Interrupt FSM states: IDLE, DRAIN, INJECT, ACTIVE.
REQ-022 IDLE->DRAIN when int_req & int_en & !mem_busy; drain counter loads INT_DRAIN-1.
REQ-023 DRAIN: pc_stall=1, if_id_flush=1; counter decrements each non-busy cycle; ->INJECT at 0.
REQ-024 INJECT (one cycle): int_inject=1, int_ack=1, pc_stall=0; ->ACTIVE.
REQ-025 ACTIVE: int_active=1, int_req ignored; ->IDLE on reti_ex & !mem_busy.
REQ-026 Branch during DRAIN: branch flushes applied, drain continues uncounted-reset.
REQ-027 int_req deasserting during DRAIN SHALL NOT abort the sequence.
REQ-028 Wait counter (8-bit) increments each mem_busy cycle, clears when mem_busy=0, saturates; mem_timeout sets when count reaches MEM_TIMEOUT, stays set until reset.
REQ-029 No event: all outputs 0.

Reset
REQ-030 rst_n low: FSM=IDLE, counters=0, mem_timeout=0, all outputs 0 immediately.
REQ-031 Reset mid-DRAIN/ACTIVE SHALL abandon the sequence; no int_ack after release.

Structure
REQ-032 Package pipe_ctrl_pkg SHALL hold the FSM state enum and register-index width constant.
REQ-033 Optional sub-module hazard_detect (combinational load-use compare, REQ-019); rest in pipeline_ctrl.

Verification
REQ-034 ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> one cycle pc_stall=if_id_stall=id_ex_flush=1; ex_rd=0 -> no stall.
REQ-035 Load-use plus branch_taken same cycle -> if_id_flush=id_ex_flush=1, pc_stall=0.
REQ-036 int_req=1, int_en=1, INT_DRAIN=3 -> 3 cycles DRAIN, then int_inject=int_ack=1 one cycle, then int_active=1 until reti_ex.
REQ-037 mem_busy for 2 cycles mid-DRAIN -> all stalls 1, injection delayed exactly 2 cycles.
REQ-038 mem_busy held 255 cycles -> mem_timeout=1 on count 255, stays 1 after mem_busy drops.
REQ-039 rst_n low in ACTIVE -> int_active=0 immediately; FSM IDLE after release.
